amt_recovery_ctrl: RTL and testbench
====================================

AMT_RECOVERY_CTRL -- requirements
Module: amt_recovery_ctrl

Interface
REQ-001 SHALL have parameter SIZE_RMT, default 34, meaning number of logical registers / AMT entries.
REQ-002 SHALL have parameter SIZE_RMT_LOG, default 6, meaning AMT index width, ceil(log2(SIZE_RMT)).
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port recoverReq_i  input  1  single-cycle pulse from ActiveList on exception or branch mispredict.
REQ-006 SHALL have port recoverBusy_o  output  1  high while AMT-to-RMT copy is in progress; stalls fetch, rename and commit.
REQ-007 SHALL have port recoverBase_o  output  SIZE_RMT_LOG  AMT read address of lane 0; lanes 1-3 read base+1..base+3.
REQ-008 SHALL have port rmtWrEn_o  output  4  per-lane RMT write enable for the current group.
REQ-009 SHALL have port commitHold_o  output  1  blocks AMT commit writes; equals recoverBusy_o.
REQ-010 SHALL have port recoverDone_o  output  1  single-cycle pulse in the cycle after the last group is written.

Function
REQ-011 SHALL implement states IDLE, WALK, DONE.
REQ-012 IDLE: recoverReq_i=1 -> WALK next cycle, base=0; otherwise stay in IDLE.
REQ-013 WALK: each cycle SHALL present base and rmtWrEn_o, then base += 4.
REQ-014 WALK -> DONE in the cycle after the group with base+4 >= SIZE_RMT is presented.
REQ-015 DONE: recoverDone_o=1 for exactly one cycle, then -> IDLE.
REQ-016 WALK SHALL last ceil(SIZE_RMT/4) cycles; with SIZE_RMT=34 that is 9 cycles: bases 0,4,...,32.
REQ-017 rmtWrEn_o bit k SHALL be 1 iff state==WALK and base+k < SIZE_RMT; the last group at SIZE_RMT=34 is 4'b0011.
REQ-018 Base arithmetic SHALL be SIZE_RMT_LOG+1 bits wide internally; lane addresses >= SIZE_RMT are never enabled, and no wrap to 0 occurs within a walk.
REQ-019 recoverBusy_o SHALL be 1 in WALK and DONE, 0 in IDLE.
REQ-020 recoverReq_i during WALK SHALL restart the walk: base=0 next cycle, state stays WALK.
REQ-021 recoverReq_i during DONE SHALL go to WALK with base=0, and recoverDone_o SHALL still pulse in that DONE cycle.
REQ-022 Outputs SHALL be registered or decoded from registered state only; there is no combinational path from recoverReq_i to any output.

Reset
REQ-023 On reset: state=IDLE, base=0, recoverBusy_o=0, commitHold_o=0, rmtWrEn_o=0, recoverDone_o=0.
REQ-024 Reset asserted mid-WALK SHALL abort the walk in the next cycle with no recoverDone_o pulse.
REQ-025 Reset SHALL take priority over a simultaneous recoverReq_i.

Structure
REQ-026 The shared package SHALL hold SIZE_RMT, SIZE_RMT_LOG, the COMMIT_WIDTH=4 constant and the state enumeration (IDLE, WALK, DONE).
REQ-027 A single sub-module amt_group_mask SHALL compute the 4-bit lane enable from base and SIZE_RMT; it is purely combinational.
REQ-028 This block SHALL replace the free-running recovery counter inside the AMT; the AMT takes recoverBase_o as its read address when commitHold_o=1.

Verification
REQ-029 Reset, then recoverReq_i pulse at cycle 10 -> busy from cycle 11 to 20; bases 0..32 over 9 cycles; rmtWrEn_o=4'hF x8 then 4'b0011; recoverDone_o at cycle 20 only.
REQ-030 With SIZE_RMT=32: request -> 8 WALK cycles, all rmtWrEn_o=4'hF, last base 28, then one DONE cycle.
REQ-031 Second recoverReq_i at the 4th WALK cycle (base=12) -> next base=0; total busy is 4+9+1 cycles; exactly one recoverDone_o pulse.
REQ-032 recoverReq_i coincident with DONE -> recoverDone_o pulses, and WALK restarts at base 0 the next cycle.
REQ-033 Reset asserted at base=16 -> next cycle IDLE, all outputs 0, no recoverDone_o pulse; a following request walks normally.
REQ-034 The bench SHALL assert, every cycle: commitHold_o==recoverBusy_o; rmtWrEn_o==0 outside WALK; no enabled lane address >= SIZE_RMT.

Source files
------------

// File: rtl/amt_recovery_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : amt_recovery_ctrl_pkg
// Brief    : Shared sizing constants and state encoding for AMT recovery.
// Revision : 1.0 - initial release
// ============================================================================
package amt_recovery_ctrl_pkg;

   localparam int SIZE_RMT     = 34;
   localparam int SIZE_RMT_LOG = 6;
   localparam int COMMIT_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WALK = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/amt_group_mask.sv
`default_nettype none
// ============================================================================
// Module   : amt_group_mask
// Brief    : Lane-enable mask for one 4-entry copy group starting at i_base.
// Revision : 1.0 - initial release
// ============================================================================
module amt_group_mask
   import amt_recovery_ctrl_pkg::*;
#(
   parameter int SIZE_RMT     = amt_recovery_ctrl_pkg::SIZE_RMT,
   parameter int SIZE_RMT_LOG = amt_recovery_ctrl_pkg::SIZE_RMT_LOG
) (
   input  logic [SIZE_RMT_LOG:0]   i_base,
   output logic [COMMIT_WIDTH-1:0] o_laneEn
);

   for (genvar k = 0; k < COMMIT_WIDTH; k++) begin : g_lane
      assign o_laneEn[k] = (32'(i_base) + 32'(k)) < 32'(SIZE_RMT);
   end

endmodule
`default_nettype wire

// File: rtl/amt_recovery_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : amt_recovery_ctrl
// Brief    : Walks the AMT four entries per cycle, copying it into the RMT.
// Revision : 1.0 - initial release
// ============================================================================
module amt_recovery_ctrl
   import amt_recovery_ctrl_pkg::*;
#(
   parameter int SIZE_RMT     = amt_recovery_ctrl_pkg::SIZE_RMT,
   parameter int SIZE_RMT_LOG = amt_recovery_ctrl_pkg::SIZE_RMT_LOG
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    recoverReq_i,
   output logic                    recoverBusy_o,
   output logic [SIZE_RMT_LOG-1:0] recoverBase_o,
   output logic [COMMIT_WIDTH-1:0] rmtWrEn_o,
   output logic                    commitHold_o,
   output logic                    recoverDone_o
);

   // One extra bit so base+4 past the table end never wraps to zero.
   localparam logic [SIZE_RMT_LOG:0] C_STEP = (SIZE_RMT_LOG + 1)'(COMMIT_WIDTH);

   state_t                  r_state;
   logic [SIZE_RMT_LOG:0]   r_base;
   logic                    r_busy;
   logic                    r_done;
   logic [COMMIT_WIDTH-1:0] r_wrEn;

   logic [SIZE_RMT_LOG:0]   w_baseInc;
   logic [SIZE_RMT_LOG:0]   w_baseNext;
   logic                    w_lastGroup;
   logic [COMMIT_WIDTH-1:0] w_maskNext;

   assign w_baseInc   = r_base + C_STEP;
   assign w_lastGroup = 32'(w_baseInc) >= 32'(SIZE_RMT);
   assign w_baseNext  = recoverReq_i ? '0 : w_baseInc;

   amt_group_mask #(
      .SIZE_RMT     (SIZE_RMT),
      .SIZE_RMT_LOG (SIZE_RMT_LOG)
   ) u_groupMask (
      .i_base   (w_baseNext),
      .o_laneEn (w_maskNext)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_base  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_wrEn  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (recoverReq_i) begin
                  r_state <= WALK;
                  r_base  <= '0;
                  r_busy  <= 1'b1;
                  r_wrEn  <= w_maskNext;
               end
            end
            WALK: begin
               // A new request restarts from base 0 instead of finishing.
               if (recoverReq_i || !w_lastGroup) begin
                  r_base <= w_baseNext;
                  r_wrEn <= w_maskNext;
               end else begin
                  r_state <= DONE;
                  r_wrEn  <= '0;
                  r_done  <= 1'b1;
               end
            end
            DONE: begin
               r_done <= 1'b0;
               r_base <= '0;
               if (recoverReq_i) begin
                  r_state <= WALK;
                  r_wrEn  <= w_maskNext;
               end else begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
               r_base  <= '0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_wrEn  <= '0;
            end
         endcase
      end
   end

   assign recoverBusy_o = r_busy;
   assign commitHold_o  = r_busy;
   assign recoverDone_o = r_done;
   assign rmtWrEn_o     = r_wrEn;
   assign recoverBase_o = r_base[SIZE_RMT_LOG-1:0];

endmodule
`default_nettype wire

// File: tb/tb_amt_recovery_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_amt_recovery_ctrl
// Brief    : Scoreboard bench for amt_recovery_ctrl at SIZE_RMT=34 and 32.
// Revision : 1.0 - initial release
// ============================================================================
module tb_amt_recovery_ctrl;

   typedef struct packed {
      logic [31:0] base;
      logic [3:0]  en;
      logic        busy;
      logic        done;
      logic        chkBase;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       recoverReq;

   logic       busy34, hold34, done34;
   logic [5:0] base34;
   logic [3:0] wrEn34;
   logic       busy32, hold32, done32;
   logic [4:0] base32;
   logic [3:0] wrEn32;

   int   total = 0;
   int   bad   = 0;
   exp_t q34[$];
   exp_t q32[$];
   int   sizes[2]  = '{34, 32};
   int   mState[2] = '{0, 0};
   int   mIdx[2]   = '{0, 0};
   int   busyCnt[2];
   int   doneCnt[2];

   always #5 clk = ~clk;

   amt_recovery_ctrl #(.SIZE_RMT(34), .SIZE_RMT_LOG(6)) dut34 (
      .clk           (clk),
      .reset         (reset),
      .recoverReq_i  (recoverReq),
      .recoverBusy_o (busy34),
      .recoverBase_o (base34),
      .rmtWrEn_o     (wrEn34),
      .commitHold_o  (hold34),
      .recoverDone_o (done34)
   );

   amt_recovery_ctrl #(.SIZE_RMT(32), .SIZE_RMT_LOG(5)) dut32 (
      .clk           (clk),
      .reset         (reset),
      .recoverReq_i  (recoverReq),
      .recoverBusy_o (busy32),
      .recoverBase_o (base32),
      .rmtWrEn_o     (wrEn32),
      .commitHold_o  (hold32),
      .recoverDone_o (done32)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Reference model: tracks group index rather than a running address.
   task automatic modelStep(input int d, input bit rst, input bit req, output exp_t e);
      int last;
      last = (sizes[d] + 3) / 4 - 1;
      if (rst) begin
         mState[d] = 0;
         mIdx[d]   = 0;
      end else begin
         case (mState[d])
            0: if (req) begin mState[d] = 1; mIdx[d] = 0; end
            1: begin
               if (req) mIdx[d] = 0;
               else if (mIdx[d] == last) mState[d] = 2;
               else mIdx[d]++;
            end
            default: begin
               mIdx[d] = 0;
               mState[d] = req ? 1 : 0;
            end
         endcase
      end
      e.busy    = (mState[d] != 0);
      e.done    = (mState[d] == 2);
      e.base    = 32'(mIdx[d] * 4);
      e.chkBase = (mState[d] == 1) || rst;
      e.en      = '0;
      if (mState[d] == 1)
         for (int k = 0; k < 4; k++)
            if (mIdx[d] * 4 + k < sizes[d]) e.en[k] = 1'b1;
   endtask

   task automatic sampleDut(input int d, input logic [31:0] base, input logic [3:0] en,
                            input logic busy, input logic hold, input logic done);
      exp_t e;
      string s;
      s = (d == 0) ? "34" : "32";
      if ((d == 0 && q34.size() == 0) || (d == 1 && q32.size() == 0)) begin
         chk({"queueEmpty", s}, 32'd0, 32'd1);
         return;
      end
      e = (d == 0) ? q34.pop_front() : q32.pop_front();
      chk({"busy", s}, 32'(busy), 32'(e.busy));
      chk({"done", s}, 32'(done), 32'(e.done));
      chk({"wrEn", s}, 32'(en), 32'(e.en));
      chk({"hold", s}, 32'(hold), 32'(busy));
      if (e.chkBase) chk({"base", s}, base, e.base);
      for (int k = 0; k < 4; k++)
         if (en[k]) chk({"laneRange", s}, 32'(base + 32'(k) < 32'(sizes[d])), 32'd1);
      if (busy) busyCnt[d]++;
      if (done) doneCnt[d]++;
   endtask

   task automatic step(input bit rst, input bit req);
      exp_t e;
      reset      = rst;
      recoverReq = req;
      modelStep(0, rst, req, e);
      q34.push_back(e);
      modelStep(1, rst, req, e);
      q32.push_back(e);
      @(posedge clk);
      #1;
      sampleDut(0, 32'(base34), wrEn34, busy34, hold34, done34);
      sampleDut(1, 32'(base32), wrEn32, busy32, hold32, done32);
   endtask

   task automatic clrCnt();
      busyCnt = '{0, 0};
      doneCnt = '{0, 0};
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      clrCnt();
      // Reset cycles 0..2, request pulse at cycle 10.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
      idle(7);
      clrCnt();
      step(1'b0, 1'b1);
      idle(12);
      chk("p1Busy34", 32'(busyCnt[0]), 32'd10);
      chk("p1Done34", 32'(doneCnt[0]), 32'd1);
      chk("p1Busy32", 32'(busyCnt[1]), 32'd9);
      chk("p1Done32", 32'(doneCnt[1]), 32'd1);

      // Restart while base 12 is presented.
      clrCnt();
      step(1'b0, 1'b1);
      idle(3);
      step(1'b0, 1'b1);
      idle(14);
      chk("p2Busy34", 32'(busyCnt[0]), 32'd14);
      chk("p2Done34", 32'(doneCnt[0]), 32'd1);
      chk("p2Busy32", 32'(busyCnt[1]), 32'd13);
      chk("p2Done32", 32'(doneCnt[1]), 32'd1);

      // Request coincident with DONE of the 34-entry walk.
      clrCnt();
      step(1'b0, 1'b1);
      idle(9);
      step(1'b0, 1'b1);
      idle(12);
      chk("p3Done34", 32'(doneCnt[0]), 32'd2);

      // Reset while base 16 is presented.
      clrCnt();
      step(1'b0, 1'b1);
      idle(4);
      step(1'b1, 1'b0);
      chk("p4Done34", 32'(doneCnt[0]), 32'd0);
      chk("p4Busy34", 32'(busy34), 32'd0);
      step(1'b0, 1'b1);
      idle(12);
      chk("p4After34", 32'(doneCnt[0]), 32'd1);

      // Reset wins over a simultaneous request.
      step(1'b1, 1'b1);
      step(1'b0, 1'b0);

      for (int i = 0; i < 300; i++)
         step($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0);
      idle(12);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
